// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 sequencing controller:
// FSM states, opcode/funct constants, ALU operation codes and instruction classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_IALU = 3'd2,
    CLS_LD   = 3'd3,
    CLS_SD   = 3'd4,
    CLS_BEQ  = 3'd5
  } class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct3/funct7[5] to an
// instruction class, the ALU operation it needs, and an illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output class_e     cls,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // Opcode/funct classification; anything not explicitly supported is illegal
  always_comb begin
    cls     = CLS_NONE;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cls = CLS_R;
        case ({funct3, funct7_5})
          {F3_ADD, 1'b0}: alu_op = ALU_ADD;
          {F3_ADD, 1'b1}: alu_op = ALU_SUB;
          {F3_AND, 1'b0}: alu_op = ALU_AND;
          {F3_OR,  1'b0}: alu_op = ALU_OR;
          default:        illegal = 1'b1;
        endcase
      end
      OP_IALU: begin
        cls = CLS_IALU;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OP_LD: begin
        cls = CLS_LD;
        if (funct3 == F3_DW) begin
          illegal = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SD: begin
        cls = CLS_SD;
        if (funct3 == F3_DW) begin
          illegal = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
        if (funct3 == F3_BEQ) begin
          illegal = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath with
// memory-ready handshake, bus timeout, sticky halt and retired-instruction count.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alusrc,
  output logic [3:0]       alu_ctrl,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_EN ? TO_W'(MEM_TIMEOUT - 1) : {TO_W{1'b0}};

  state_e           state_r, next_state_s;
  class_e           cls_r, dec_cls_s;
  logic [3:0]       alu_r, dec_alu_s;
  logic             dec_illegal_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic [CNT_W-1:0] retired_r;
  logic             halted_r, bus_err_r;
  logic             wait_s, timeout_s;
  logic             latch_cls_s, retire_s, set_halt_s, set_bus_err_s;

  ctrl_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .cls      (dec_cls_s),
    .alu_op   (dec_alu_s),
    .illegal  (dec_illegal_s)
  );

  // Waiting on memory in a handshake state; the limit cycle only errors without mem_ready
  assign wait_s    = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
  assign timeout_s = TO_EN && wait_s && (to_cnt_r == TO_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and bookkeeping strobes
  always_comb begin
    next_state_s  = state_r;
    latch_cls_s   = 1'b0;
    retire_s      = 1'b0;
    set_halt_s    = 1'b0;
    set_bus_err_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          next_state_s  = ST_HALT;
          set_halt_s    = 1'b1;
          set_bus_err_s = 1'b1;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          next_state_s = ST_HALT;
          set_halt_s   = 1'b1;
        end else begin
          next_state_s = ST_EXEC;
          latch_cls_s  = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls_r)
          CLS_R, CLS_IALU: next_state_s = ST_WB;
          CLS_LD, CLS_SD:  next_state_s = ST_MEM;
          CLS_BEQ: begin
            next_state_s = ST_FETCH;
            retire_s     = 1'b1;
          end
          default: begin
            next_state_s = ST_HALT;
            set_halt_s   = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          case (cls_r)
            CLS_LD: next_state_s = ST_WB;
            CLS_SD: begin
              next_state_s = ST_FETCH;
              retire_s     = 1'b1;
            end
            default: begin
              next_state_s = ST_HALT;
              set_halt_s   = 1'b1;
            end
          endcase
        end else if (timeout_s) begin
          next_state_s  = ST_HALT;
          set_halt_s    = 1'b1;
          set_bus_err_s = 1'b1;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        next_state_s = ST_FETCH;
        retire_s     = 1'b1;
      end
      ST_HALT: next_state_s = ST_HALT;
      default: begin
        next_state_s = ST_HALT;
        set_halt_s   = 1'b1;
      end
    endcase
  end

  // Class latch, timeout counter, retire counter and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      cls_r     <= CLS_NONE;
      alu_r     <= ALU_AND;
      to_cnt_r  <= {TO_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
      halted_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      if (latch_cls_s) begin
        cls_r <= dec_cls_s;
        alu_r <= dec_alu_s;
      end
      if (wait_s && (next_state_s == state_r)) begin
        to_cnt_r <= to_cnt_r + 1'b1;
      end else begin
        to_cnt_r <= {TO_W{1'b0}};
      end
      if (retire_s) begin
        retired_r <= retired_r + 1'b1;
      end
      if (set_halt_s) begin
        halted_r <= 1'b1;
      end
      if (set_bus_err_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  // Datapath controls; everything is forced low while reset is held
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alusrc     = 1'b0;
    alu_ctrl   = 4'b0000;
    state_dbg  = 3'd0;
    if (!reset) begin
      state_dbg = 3'd0;
    end else begin
      state_dbg = state_r;
      case (state_r)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        ST_EXEC: begin
          case (cls_r)
            CLS_R: begin
              alusrc   = 1'b0;
              alu_ctrl = alu_r;
            end
            CLS_IALU: begin
              alusrc   = 1'b1;
              alu_ctrl = alu_r;
            end
            CLS_LD, CLS_SD: begin
              alusrc   = 1'b1;
              alu_ctrl = ALU_ADD;
            end
            CLS_BEQ: begin
              alusrc   = 1'b0;
              alu_ctrl = ALU_SUB;
              pc_write = 1'b1;
              pc_src   = zero;
            end
            default: alu_ctrl = 4'b0000;
          endcase
        end
        ST_MEM: begin
          case (cls_r)
            CLS_LD: mem_read = 1'b1;
            CLS_SD: begin
              mem_write = 1'b1;
              pc_write  = mem_ready;
            end
            default: mem_read = 1'b0;
          endcase
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_r == CLS_LD);
          pc_write   = 1'b1;
        end
        default: pc_write = 1'b0;
      endcase
    end
  end

  assign halted  = reset & halted_r;
  assign bus_err = reset & bus_err_r;
  assign retired = reset ? retired_r : {CNT_W{1'b0}};

endmodule
